// File: rtl/func_pkg.sv
// Shared widths, FSM state type, operand vector table and reference model
// for the func responder self-test.
package func_pkg;

  localparam int unsigned A_W       = 8;
  localparam int unsigned Y_W       = 24;
  localparam int unsigned VEC_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_LO,
    ST_CHECK,
    ST_NEXT,
    ST_DONE
  } state_t;

  // {a, b} per index; entries past the 10 defined vectors read as (0,0).
  localparam logic [2*A_W-1:0] VEC_TAB [16] = '{
    {8'd0,   8'd0},
    {8'd1,   8'd0},
    {8'd1,   8'd1},
    {8'd2,   8'd2},
    {8'd15,  8'd240},
    {8'd240, 8'd15},
    {8'd170, 8'd85},
    {8'd85,  8'd170},
    {8'd100, 8'd125},
    {8'd255, 8'd255},
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  // y = a*b + a^3; the largest case (255,255) is 16646400 and fits in 24 bits.
  function automatic logic [Y_W-1:0] func_ref(input logic [A_W-1:0] a,
                                               input logic [A_W-1:0] b);
    logic [Y_W-1:0] wa;
    logic [Y_W-1:0] wb;
    wa = Y_W'(a);
    wb = Y_W'(b);
    return wa * wb + wa * wa * wa;
  endfunction

endpackage

// File: rtl/func_vec_rom.sv
// Combinational lookup of the self-test operand pair for a vector index.
module func_vec_rom
  import func_pkg::*;
(
  input  logic [VEC_IDX_W-1:0] i_idx,
  output logic [A_W-1:0]       o_a,
  output logic [A_W-1:0]       o_b
);

  always_comb begin
    {o_a, o_b} = VEC_TAB[i_idx];
  end

endmodule

// File: rtl/func_bist.sv
// Built-in self-test initiator for func: walks the vector table through the
// start/busy handshake, checks each result and reports pass/fail.
module func_bist
  import func_pkg::*;
#(
  parameter int unsigned NUM_VEC = 10,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  output logic [A_W-1:0]       a_o,
  output logic [A_W-1:0]       b_o,
  output logic                 start_o,
  input  logic [Y_W-1:0]       y_i,
  input  logic                 busy_i,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [4:0]           fail_cnt_o,
  output logic [3:0]           first_fail_o,
  output logic [VEC_IDX_W-1:0] vec_idx_o
);

  localparam int unsigned            TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]       TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [VEC_IDX_W-1:0]   LAST_IDX = VEC_IDX_W'(NUM_VEC - 1);

  state_t           r_state;
  logic             r_run_q;
  logic [Y_W-1:0]   r_exp;
  logic [TMO_W-1:0] r_tmo;

  logic [A_W-1:0]   w_rom_a;
  logic [A_W-1:0]   w_rom_b;
  logic             w_start_req;
  logic             w_tmo_hit;
  logic [4:0]       w_cnt_inc;
  logic [3:0]       w_first_next;

  func_vec_rom u_rom (
    .i_idx (vec_idx_o),
    .o_a   (w_rom_a),
    .o_b   (w_rom_b)
  );

  assign w_start_req  = run_i & ~r_run_q;
  assign w_tmo_hit    = (r_tmo == TMO_LAST);
  assign w_cnt_inc    = (fail_cnt_o == 5'd31) ? fail_cnt_o : fail_cnt_o + 5'd1;
  assign w_first_next = (first_fail_o == 4'hF) ? vec_idx_o : first_fail_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_run_q      <= 1'b0;
      r_exp        <= '0;
      r_tmo        <= '0;
      a_o          <= '0;
      b_o          <= '0;
      start_o      <= 1'b0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      fail_cnt_o   <= '0;
      first_fail_o <= 4'hF;
      vec_idx_o    <= '0;
    end else begin
      r_run_q <= run_i;
      // Counter only survives a cycle that stays in a wait state.
      r_tmo   <= '0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          start_o <= 1'b0;
          if (w_start_req) begin
            r_state      <= ST_LOAD;
            done_o       <= 1'b0;
            pass_o       <= 1'b0;
            fail_cnt_o   <= '0;
            first_fail_o <= 4'hF;
            vec_idx_o    <= '0;
          end
        end
        ST_LOAD: begin
          a_o     <= w_rom_a;
          b_o     <= w_rom_b;
          r_exp   <= func_ref(w_rom_a, w_rom_b);
          start_o <= 1'b1;
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (busy_i) begin
            start_o <= 1'b0;
            r_state <= ST_WAIT_LO;
          end else if (w_tmo_hit) begin
            start_o      <= 1'b0;
            fail_cnt_o   <= w_cnt_inc;
            first_fail_o <= w_first_next;
            r_state      <= ST_NEXT;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!busy_i) begin
            r_state <= ST_CHECK;
          end else if (w_tmo_hit) begin
            fail_cnt_o   <= w_cnt_inc;
            first_fail_o <= w_first_next;
            r_state      <= ST_NEXT;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        ST_CHECK: begin
          if (y_i != r_exp) begin
            fail_cnt_o   <= w_cnt_inc;
            first_fail_o <= w_first_next;
          end
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (vec_idx_o == LAST_IDX) begin
            done_o  <= 1'b1;
            pass_o  <= (fail_cnt_o == '0);
            r_state <= ST_DONE;
          end else begin
            vec_idx_o <= vec_idx_o + VEC_IDX_W'(1);
            r_state   <= ST_LOAD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/func_bist.md
Name: func_bist

Overview:
- Built-in self-test initiator for the `func` responder (y = a*b + a^3, 8-bit operands, 24-bit result, start/busy handshake).
- Walks a fixed table of 10 operand vectors and drives `func` through its start/busy handshake for each one.
- Captures each result and compares it against an internally computed expected value.
- Reports completion, pass/fail, failure count and first failing index. Sits beside `func` in the lab top level and replaces the simulation-only checker with synthesizable logic.

Parameters:
- NUM_VEC, 10, number of vectors walked from the table (1..16).
- TIMEOUT, 1023, max cycles spent in any wait state before the vector is declared failed.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  synchronous, active-low reset (sampled on clk_i rising edge; 0 = reset).
- run_i  input  1  level; a rising edge seen in IDLE or DONE starts a full pass.
- a_o  output  8  operand a to func.a_i.
- b_o  output  8  operand b to func.b_i.
- start_o  output  1  to func.start_i.
- y_i  input  24  from func.y_o.
- busy_i  input  1  from func.busy.
- done_o  output  1  high once the pass completes; held until the next run or reset.
- pass_o  output  1  valid when done_o=1; 1 iff fail_cnt_o==0.
- fail_cnt_o  output  5  number of failed vectors, saturating at 31.
- first_fail_o  output  4  index of the first failing vector; 4'hF if none.
- vec_idx_o  output  4  index of the vector in flight.

Behaviour:
- Reset values (rst_i=0 at a clock edge), with priority over everything: state=IDLE; a_o=b_o=0; start_o=0; done_o=0; pass_o=0; fail_cnt_o=0; first_fail_o=4'hF; vec_idx_o=0; timeout counter=0. Reset mid-pass aborts immediately; start_o drops in the same edge.
- run_i edge detect: register run_q; start condition is run_i & ~run_q while in IDLE or DONE. Rising edges in any other state are ignored.
- FSM states: IDLE, LOAD, ISSUE, WAIT_LO, CHECK, NEXT, DONE.
- IDLE -> LOAD on start condition. Clears done_o, fail_cnt_o, first_fail_o, vec_idx_o.
- LOAD (1 cycle): a_o/b_o <= table[vec_idx]; expected register <= a*b + a*a*a computed at 24 bits (max 16646400, no overflow); -> ISSUE.
- ISSUE: start_o=1, held until busy_i=1 is sampled, then start_o=0 and -> WAIT_LO.
  - If busy_i is never seen within TIMEOUT cycles: record fail, -> NEXT.
  - busy_i=1 already high on entry is treated as acknowledgment.
- WAIT_LO: operands held stable; wait for busy_i=0; -> CHECK. Timeout: record fail, -> NEXT.
- CHECK (1 cycle): y_i sampled; mismatch with expected records a fail; -> NEXT.
- Recording a fail: fail_cnt_o+1 (saturating); if first_fail_o==F then first_fail_o<=vec_idx.
- NEXT: if vec_idx==NUM_VEC-1 -> DONE, else vec_idx+1 and -> LOAD.
- DONE: done_o=1; pass_o=(fail_cnt_o==0); start_o=0. Results held. -> LOAD on a new start condition, re-clearing as in IDLE.
- Timeout counter clears on every state change.
- Per-vector latency is 3 cycles + func latency + handshake; no pipelining, one vector in flight.

Decomposition:
- Package func_pkg:
  - widths A_W=8, Y_W=24, VEC_IDX_W=4.
  - state enum.
  - 10-entry vector constants (a,b): (0,0) (1,0) (1,1) (2,2) (15,240) (240,15) (170,85) (85,170) (100,125) (255,255).
  - function func_ref(a,b), shared with the bench.
- Sub-module func_vec_rom: combinational index -> {a,b} lookup from the package constants.

Test Plan:
- Golden pass: func_bist wired to real func, pulse run_i -> done_o=1, pass_o=1, fail_cnt_o=0, first_fail_o=F. The bench observes y_i values 0,1,2,12,6975,13827600,4927450,628575,1012500,16646400 in index order.
- Injected fault: behavioural func model returns y+1 for vector 6 only -> done_o=1, pass_o=0, fail_cnt_o=1, first_fail_o=6.
- Timeout: model never raises busy_i, TIMEOUT=15 -> every vector times out, fail_cnt_o=10, first_fail_o=0. start_o is held high 15 cycles per vector, then dropped.
- Handshake: model raises busy 3 cycles after start and holds it 20 cycles -> start_o drops the cycle after busy is sampled high. a_o/b_o stay stable until CHECK; pass_o=1.
- Reset mid-pass: assert rst_i=0 while at vec_idx=4 in WAIT_LO -> next edge gives all outputs at reset values and start_o=0. A new run_i edge gives a clean full pass, pass_o=1.
- Re-run: pulse run_i while in DONE -> done_o clears, pass repeats with identical results. A run_i edge mid-pass is ignored.
